// File: rtl/tdc_meas_sequencer_if.sv
// Host/datapath signal bundle for tdc_meas_sequencer.
// Optional result_min/result_max are present when TDC_MINMAX_EN is defined.
interface tdc_meas_sequencer_if #(
  parameter int unsigned CODE_W   = 8,
  parameter int unsigned AVG_LOG2 = 2
);
  logic                       start;
  logic                       cfg_pls_src;
  logic                       cfg_tog;
  logic [1:0]                 cfg_delay_line;
  logic                       ctl_pls_src;
  logic                       ctl_tog;
  logic [1:0]                 ctl_delay_line;
  logic                       launch;
  logic                       tdc_valid;
  logic [CODE_W-1:0]          tdc_code;
  logic                       busy;
  logic                       done;
  logic                       err;
  logic [CODE_W+AVG_LOG2-1:0] result_sum;
  logic [CODE_W-1:0]          result_avg;
`ifdef TDC_MINMAX_EN
  logic [CODE_W-1:0]          result_min;
  logic [CODE_W-1:0]          result_max;
`endif

  // Sequencer side.
  modport master (
    input  start, cfg_pls_src, cfg_tog, cfg_delay_line, tdc_valid, tdc_code,
    output ctl_pls_src, ctl_tog, ctl_delay_line, launch, busy, done, err,
           result_sum, result_avg
`ifdef TDC_MINMAX_EN
    , output result_min, result_max
`endif
  );

  // Host / datapath side.
  modport slave (
    output start, cfg_pls_src, cfg_tog, cfg_delay_line, tdc_valid, tdc_code,
    input  ctl_pls_src, ctl_tog, ctl_delay_line, launch, busy, done, err,
           result_sum, result_avg
`ifdef TDC_MINMAX_EN
    , input result_min, result_max
`endif
  );
endinterface

// File: rtl/tdc_meas_sequencer.sv
// TDC measurement sequencer: latch config, settle, launch 2^AVG_LOG2 pulses, accumulate codes.
// Define TDC_MINMAX_EN to add min/max tracking of accepted codes.
module tdc_meas_sequencer #(
  parameter int unsigned CODE_W         = 8,
  parameter int unsigned AVG_LOG2       = 2,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  tdc_meas_sequencer_if.master bus
);
  localparam int unsigned SUM_W = CODE_W + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StSettle, StLaunch, StWait, StDone} state_e;

  state_e             state_q, state_d;
  logic               ctl_pls_src_q, ctl_pls_src_d;
  logic               ctl_tog_q, ctl_tog_d;
  logic [1:0]         ctl_dl_q, ctl_dl_d;
  logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0]   smp_cnt_q, smp_cnt_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [SUM_W-1:0]   acc_next;
  logic               err_q, err_d;
  logic [SUM_W-1:0]   res_sum_q, res_sum_d;
`ifdef TDC_MINMAX_EN
  logic [CODE_W-1:0]  trk_min_q, trk_min_d, trk_max_q, trk_max_d;
  logic [CODE_W-1:0]  min_next, max_next;
  logic [CODE_W-1:0]  res_min_q, res_min_d, res_max_q, res_max_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      ctl_pls_src_q <= 1'b0;
      ctl_tog_q     <= 1'b0;
      ctl_dl_q      <= 2'd0;
      set_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      smp_cnt_q     <= '0;
      acc_q         <= '0;
      err_q         <= 1'b0;
      res_sum_q     <= '0;
`ifdef TDC_MINMAX_EN
      trk_min_q     <= '0;
      trk_max_q     <= '0;
      res_min_q     <= '0;
      res_max_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ctl_pls_src_q <= ctl_pls_src_d;
      ctl_tog_q     <= ctl_tog_d;
      ctl_dl_q      <= ctl_dl_d;
      set_cnt_q     <= set_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      smp_cnt_q     <= smp_cnt_d;
      acc_q         <= acc_d;
      err_q         <= err_d;
      res_sum_q     <= res_sum_d;
`ifdef TDC_MINMAX_EN
      trk_min_q     <= trk_min_d;
      trk_max_q     <= trk_max_d;
      res_min_q     <= res_min_d;
      res_max_q     <= res_max_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    ctl_pls_src_d = ctl_pls_src_q;
    ctl_tog_d     = ctl_tog_q;
    ctl_dl_d      = ctl_dl_q;
    set_cnt_d     = set_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    smp_cnt_d     = smp_cnt_q;
    acc_d         = acc_q;
    err_d         = err_q;
    res_sum_d     = res_sum_q;
    acc_next      = acc_q + SUM_W'(bus.tdc_code);
`ifdef TDC_MINMAX_EN
    trk_min_d     = trk_min_q;
    trk_max_d     = trk_max_q;
    res_min_d     = res_min_q;
    res_max_d     = res_max_q;
    // First accepted sample seeds both trackers.
    min_next = (smp_cnt_q == '0 || bus.tdc_code < trk_min_q) ? bus.tdc_code : trk_min_q;
    max_next = (smp_cnt_q == '0 || bus.tdc_code > trk_max_q) ? bus.tdc_code : trk_max_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d       = StSettle;
          ctl_pls_src_d = bus.cfg_pls_src;
          ctl_tog_d     = bus.cfg_tog;
          ctl_dl_d      = bus.cfg_delay_line;
          set_cnt_d     = '0;
          smp_cnt_d     = '0;
          acc_d         = '0;
          err_d         = 1'b0;
        end
      end
      StSettle: begin
        if (set_cnt_q == SET_LAST) state_d = StLaunch;
        else set_cnt_d = set_cnt_q + 1'b1;
      end
      StLaunch: begin
        tmo_cnt_d = '0;
        state_d   = StWait;
      end
      StWait: begin
        // A valid on the final timeout cycle still counts as a sample.
        if (bus.tdc_valid) begin
          acc_d     = acc_next;
          smp_cnt_d = smp_cnt_q + 1'b1;
`ifdef TDC_MINMAX_EN
          trk_min_d = min_next;
          trk_max_d = max_next;
`endif
          if (smp_cnt_q == CNT_LAST) begin
            state_d   = StDone;
            res_sum_d = acc_next;
`ifdef TDC_MINMAX_EN
            res_min_d = min_next;
            res_max_d = max_next;
`endif
          end else begin
            state_d = StLaunch;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.launch = (state_q == StLaunch);
    bus.done   = (state_q == StDone);
    bus.busy   = (state_q != StIdle);
  end

  assign bus.ctl_pls_src    = ctl_pls_src_q;
  assign bus.ctl_tog        = ctl_tog_q;
  assign bus.ctl_delay_line = ctl_dl_q;
  assign bus.err            = err_q;
  assign bus.result_sum     = res_sum_q;
  assign bus.result_avg     = CODE_W'(res_sum_q >> AVG_LOG2);
`ifdef TDC_MINMAX_EN
  assign bus.result_min     = res_min_q;
  assign bus.result_max     = res_max_q;
`endif

endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// Directed bench for tdc_meas_sequencer (default parameters: CODE_W=8, AVG_LOG2=2,
// SETTLE_CYCLES=4, TIMEOUT_CYCLES=16). Checks min/max when TDC_MINMAX_EN is defined.
module tb_tdc_meas_sequencer;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   launch_cnt = 0;
  int   done_cnt   = 0;
  int   l0, d0;

  tdc_meas_sequencer_if #(.CODE_W(8), .AVG_LOG2(2)) bus ();

  tdc_meas_sequencer #(
    .CODE_W(8), .AVG_LOG2(2), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.launch === 1'b1) launch_cnt++;
    if (bus.done === 1'b1) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_idle_reset();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_launch", 32'(bus.launch), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_ctl_pls", 32'(bus.ctl_pls_src), 0);
    chk("rst_ctl_tog", 32'(bus.ctl_tog), 0);
    chk("rst_ctl_dl", 32'(bus.ctl_delay_line), 0);
    chk("rst_sum", 32'(bus.result_sum), 0);
    chk("rst_avg", 32'(bus.result_avg), 0);
  endtask

  // One full measurement; each code returned 3 cycles after its launch.
  // noise: pulse start/tdc_valid and change cfg during SETTLE and the first LAUNCH.
  task automatic measure(input logic ps, input logic tg, input logic [1:0] dl,
                         input logic [7:0] codes [4], input int exp_sum, input int exp_avg,
                         input bit noise);
    int la, da;
`ifdef TDC_MINMAX_EN
    logic [7:0] mn, mx;
    mn = codes[0];
    mx = codes[0];
    for (int k = 1; k < 4; k++) begin
      if (codes[k] < mn) mn = codes[k];
      if (codes[k] > mx) mx = codes[k];
    end
`endif
    la = launch_cnt;
    da = done_cnt;
    bus.cfg_pls_src    = ps;
    bus.cfg_tog        = tg;
    bus.cfg_delay_line = dl;
    bus.start          = 1'b1;
    step();  // cycle T+1
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 1);
    chk("err_cleared", 32'(bus.err), 0);
    chk("ctl_pls", 32'(bus.ctl_pls_src), 32'(ps));
    chk("ctl_tog", 32'(bus.ctl_tog), 32'(tg));
    chk("ctl_dl", 32'(bus.ctl_delay_line), 32'(dl));
    if (noise) begin
      bus.start = 1'b1;
      bus.tdc_valid = 1'b1;
      bus.tdc_code = 8'd200;
      bus.cfg_pls_src = ~ps;
      bus.cfg_tog = ~tg;
      bus.cfg_delay_line = ~dl;
    end
    for (int i = 0; i < 3; i++) begin
      chk("settle_no_launch", 32'(bus.launch), 0);
      step();
    end
    chk("settle_no_launch", 32'(bus.launch), 0);
    step();  // cycle T+5
    for (int i = 0; i < 4; i++) begin
      chk("launch_pulse", 32'(bus.launch), 1);
      step();  // L+1
      bus.start = 1'b0;
      bus.tdc_valid = 1'b0;
      chk("launch_one_cycle", 32'(bus.launch), 0);
      step();  // L+2
      chk("busy_in_wait", 32'(bus.busy), 1);
      step();  // L+3
      bus.tdc_valid = 1'b1;
      bus.tdc_code = codes[i];
      step();  // L+4
      bus.tdc_valid = 1'b0;
    end
    chk("done_pulse", 32'(bus.done), 1);
    chk("done_sum", 32'(bus.result_sum), 32'(exp_sum));
    chk("done_avg", 32'(bus.result_avg), 32'(exp_avg));
    chk("done_err", 32'(bus.err), 0);
    chk("ctl_hold_pls", 32'(bus.ctl_pls_src), 32'(ps));
    chk("ctl_hold_dl", 32'(bus.ctl_delay_line), 32'(dl));
`ifdef TDC_MINMAX_EN
    chk("done_min", 32'(bus.result_min), 32'(mn));
    chk("done_max", 32'(bus.result_max), 32'(mx));
`endif
    step();
    chk("idle_done_low", 32'(bus.done), 0);
    chk("idle_busy_low", 32'(bus.busy), 0);
    chk("launch_count", 32'(launch_cnt - la), 4);
    chk("done_count", 32'(done_cnt - da), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.cfg_pls_src = 1'b0;
    bus.cfg_tog = 1'b0;
    bus.cfg_delay_line = 2'd0;
    bus.tdc_valid = 1'b0;
    bus.tdc_code = 8'd0;
    step();
    step();
    chk_idle_reset();
    rst_n = 1'b1;
    step();

    // Basic averaging: 10+12+14+16.
    measure(1'b1, 1'b1, 2'd1, '{8'd10, 8'd12, 8'd14, 8'd16}, 52, 13, 1'b0);
    // Same stimulus with start/valid/cfg noise during SETTLE and LAUNCH.
    measure(1'b1, 1'b1, 2'd1, '{8'd10, 8'd12, 8'd14, 8'd16}, 52, 13, 1'b1);

    // Timeout with reserved delay-line code.
    l0 = launch_cnt;
    d0 = done_cnt;
    bus.cfg_pls_src = 1'b0;
    bus.cfg_tog = 1'b1;
    bus.cfg_delay_line = 2'd2;
    bus.start = 1'b1;
    step();  // T+1
    bus.start = 1'b0;
    chk("tmo_ctl_dl_reserved", 32'(bus.ctl_delay_line), 2);
    for (int i = 0; i < 4; i++) step();  // T+5
    chk("tmo_launch", 32'(bus.launch), 1);
    step();  // WAIT entry W
    for (int i = 0; i < 15; i++) step();  // W+15
    chk("tmo_not_yet", 32'(bus.done), 0);
    step();  // W+16
    chk("tmo_done", 32'(bus.done), 1);
    chk("tmo_err", 32'(bus.err), 1);
    chk("tmo_sum_kept", 32'(bus.result_sum), 52);
    chk("tmo_avg_kept", 32'(bus.result_avg), 13);
    chk("tmo_single_launch", 32'(launch_cnt - l0), 1);
    step();
    chk("tmo_idle", 32'(bus.busy), 0);
    chk("tmo_err_held", 32'(bus.err), 1);
    chk("tmo_done_count", 32'(done_cnt - d0), 1);

    // Full-scale codes; also confirms the new start clears err.
    measure(1'b0, 1'b0, 2'd3, '{8'd255, 8'd255, 8'd255, 8'd255}, 1020, 255, 1'b0);
    measure(1'b1, 1'b0, 2'd0, '{8'd3, 8'd9, 8'd1, 8'd7}, 20, 5, 1'b0);

    // Reset in the middle of WAIT.
    bus.cfg_pls_src = 1'b1;
    bus.cfg_tog = 1'b0;
    bus.cfg_delay_line = 2'd1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("rst_mid_launch", 32'(bus.launch), 1);
    step();  // WAIT
    d0 = done_cnt;
    rst_n = 1'b0;
    step();
    step();
    chk_idle_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("rst_no_done", 32'(done_cnt - d0), 0);
    chk("rst_stays_idle", 32'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tdc_meas_sequencer.md
Name: tdc_meas_sequencer

Overview:
- Measurement controller for the TDC wrapper datapath.
- Latches a control-CSR configuration: pulse source, toggle mode and delay-line select.
- Drives that configuration to the datapath, waits a settle time, then fires 2^AVG_LOG2 launch pulses and accumulates the returned TDC codes.
- Reports sum and average, or a timeout error; sits between the host/CSR interface and the pulse generator + delay line.

Parameters:
- CODE_W, 8, width of the TDC code returned by the delay line
- AVG_LOG2, 2, log2 of samples per measurement (2^AVG_LOG2 launches)
- SETTLE_CYCLES, 4, cycles (>=1) held after config update before the first launch
- TIMEOUT_CYCLES, 16, max cycles (>=1) waited for tdc_valid after each launch

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request a measurement, sampled only in IDLE
- cfg_pls_src  in  1  pulse source: 0=PG_IN, 1=PG_TOG
- cfg_tog  in  1  toggle mode: 0=TOG_BYP, 1=TOG_REG
- cfg_delay_line  in  2  delay line: 0=MUX, 1=ADD, 2..3 reserved
- ctl_pls_src  out  1  registered pulse-source select to datapath
- ctl_tog  out  1  registered toggle select to datapath
- ctl_delay_line  out  2  registered delay-line select to datapath
- launch  out  1  one-cycle pulse to pulse generator
- tdc_valid  in  1  TDC code valid strobe
- tdc_code  in  CODE_W  TDC code, qualified by tdc_valid
- busy  out  1  high from cycle after accepted start until return to IDLE
- done  out  1  one-cycle pulse at end of measurement (success or error)
- err  out  1  timeout flag, set with done, cleared on next accepted start
- result_sum  out  CODE_W+AVG_LOG2  sum of codes, updated with done
- result_avg  out  CODE_W  result_sum >> AVG_LOG2 (truncating)

Behaviour:
- Reset (rst_n=0 at clk edge): all outputs 0, ctl_* = PG_IN/TOG_BYP/MUX, FSM=IDLE, counters 0.
- States: IDLE, SETTLE, LAUNCH, WAIT, DONE.
- IDLE, start=1 at edge T:
  - latch cfg_* into ctl_*, clear accumulator, sample count and err.
  - busy=1 and new ctl_* visible from T+1; go SETTLE.
  - Reserved cfg_delay_line (2, 3): passed through unchanged.
- SETTLE: stay exactly SETTLE_CYCLES cycles, then LAUNCH. First launch is high in cycle T+1+SETTLE_CYCLES.
- LAUNCH: launch=1 for exactly one cycle; clear timeout counter; go WAIT.
- WAIT:
  - tdc_valid=1: sum += tdc_code (zero-extended, no overflow by width), count++.
    - count reaching 2^AVG_LOG2: go DONE.
    - otherwise go LAUNCH; next launch comes the cycle after the valid.
  - tdc_valid=1 in the same cycle the timeout counter reaches TIMEOUT_CYCLES: valid wins.
  - Timeout (TIMEOUT_CYCLES cycles without tdc_valid): set err, go DONE; result_sum/avg keep their previous values.
- DONE (one cycle):
  - done=1; on success, result_sum/result_avg updated the same cycle.
  - busy=0 from the next cycle; return to IDLE.
- ctl_* hold last configuration in IDLE; changed only by an accepted start or reset.
- start outside IDLE ignored; start in DONE cycle ignored.
- tdc_valid outside WAIT ignored; no accumulation.
- Reset mid-operation: abort next edge to reset values; no done pulse.

Optional Feature:
- TDC_MINMAX_EN:
  - Adds outputs result_min and result_max (CODE_W each), updated with done on success.
  - Tracks min/max of codes accepted during the measurement; reset to 0.
- Without the macro: ports and logic absent; the rest is identical.

Test Plan:
1. Hold rst_n=0 for 2 edges mid-WAIT, then release -> all outputs 0, ctl_*=0, busy=0, no done pulse.
2. AVG_LOG2=2, SETTLE=4; start with cfg=(1,1,1); codes 10,12,14,16 each 3 cycles after launch -> ctl_*=(1,1,1) from T+1; first launch at T+5; 4 launches total; done once; result_sum=52, result_avg=13, err=0.
3. Start, then never assert tdc_valid -> single launch; done+err exactly TIMEOUT_CYCLES cycles after WAIT entry; result_sum unchanged; next start clears err.
4. Pulse start during SETTLE and tdc_valid during SETTLE/LAUNCH -> no restart, no accumulation; sum still 52 for the stimulus of test 2.
5. Codes 255,255,255,255 (CODE_W=8) -> result_sum=1020, result_avg=255; with TDC_MINMAX_EN, codes 3,9,1,7 -> min=1, max=9.
